pc_ctrl_scheduler: RTL and testbench

- Generates the 2-bit ctrl signal and the 64-bit new-PC that drive the PC/fetch register stage.
- Arbitrates redirect sources (trap from WB, branch from EX) against stall sources (icache, load-use hazard, dcache).
- Holds any redirect that arrives while fetch is stalled, so no redirect is lost; the PC stage ignores the new-PC input while stalled.
- Sits between the hazard/branch units and the PC stage. Also provides a post-reset boot hold and a stall watchdog.

---
 rtl/pc_ctrl_scheduler_if.sv | 47 ++++
 rtl/pc_ctrl_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_pc_ctrl_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_scheduler_if.sv
// ============================================================================
// Module      : pc_ctrl_scheduler_if
// Description : Bundles the redirect, stall and PC-control signals between the
//               hazard/branch units (master) and pc_ctrl_scheduler (slave).
//               Also defines the shared ctrl-signal encodings.
// Ports       : master drives trap/branch redirects and stall sources and
//               observes ctrl/pc/flush/pending/timeout; slave is the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`define CTRL_STATE_Branch  2'b01
`define CTRL_STATE_Stalled 2'b10
`endif

interface pc_ctrl_scheduler_if;
    logic        trap_valid_i;
    logic [63:0] trap_pc_i;
    logic        branch_valid_i;
    logic [63:0] branch_pc_i;
    logic        icache_stall_i;
    logic        hazard_stall_i;
    logic        dcache_stall_i;
    logic [1:0]  ctrl_signal_o;
    logic [63:0] pc_new_o;
    logic        flush_o;
    logic        redirect_pending_o;
    logic        stall_timeout_o;

    modport master (
        output trap_valid_i, trap_pc_i, branch_valid_i, branch_pc_i,
               icache_stall_i, hazard_stall_i, dcache_stall_i,
        input  ctrl_signal_o, pc_new_o, flush_o, redirect_pending_o,
               stall_timeout_o
    );

    modport slave (
        input  trap_valid_i, trap_pc_i, branch_valid_i, branch_pc_i,
               icache_stall_i, hazard_stall_i, dcache_stall_i,
        output ctrl_signal_o, pc_new_o, flush_o, redirect_pending_o,
               stall_timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/pc_ctrl_scheduler.sv
// ============================================================================
// Module      : pc_ctrl_scheduler
// Description : Produces the 2-bit ctrl and 64-bit new-PC for the PC/fetch
//               stage. Arbitrates trap/branch redirects against icache,
//               load-use and dcache stalls, parks a redirect that arrives
//               while stalled, holds fetch for BOOT_WAIT cycles after reset
//               and flags stalls that last STALL_TIMEOUT cycles.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - pc_ctrl_scheduler_if.slave (redirects, stalls, ctrl,
//                      pc_new, flush, redirect_pending, stall_timeout)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ctrl_scheduler #(
    parameter int BOOT_WAIT     = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pc_ctrl_scheduler_if.slave bus
);

    localparam logic [1:0] c_ST_BOOT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // With no boot wait the design comes out of reset directly in RUN.
    localparam logic [1:0] c_RESET_STATE = (BOOT_WAIT == 0) ? c_ST_RUN : c_ST_BOOT;

    localparam int                  c_BOOT_W    = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT + 1) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_INIT = c_BOOT_W'(BOOT_WAIT);
    localparam logic [c_BOOT_W-1:0] c_BOOT_ONE  = c_BOOT_W'(1);
    localparam logic [15:0]         c_TIMEOUT   = 16'(STALL_TIMEOUT);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_BOOT_W-1:0] r_boot_cnt;
    logic                r_pend_trap;
    logic [63:0]         r_pend_pc;
    logic [15:0]         r_wd_cnt;
    logic [15:0]         w_wd_nxt;
    logic                r_timeout;

    logic                w_stall;
    logic                w_in_boot;
    logic                w_hold;
    logic                w_trap_acc;
    logic                w_branch_acc;
    logic                w_sel_valid;
    logic [63:0]         w_sel_pc;
    logic [1:0]          w_ctrl;
    logic [63:0]         w_pc_new;
    logic                w_flush;

    assign w_stall   = bus.icache_stall_i | bus.hazard_stall_i | bus.dcache_stall_i;
    assign w_in_boot = (r_state == c_ST_BOOT);
    assign w_hold    = (r_state == c_ST_HOLD);

    // A branch seen while a redirect is parked comes from a younger,
    // already-flushed instruction and is dropped.
    assign w_trap_acc   = bus.trap_valid_i & ~w_in_boot;
    assign w_branch_acc = bus.branch_valid_i & ~w_in_boot & ~w_hold;
    assign w_sel_valid  = w_trap_acc | w_hold | w_branch_acc;

    // Priority: live trap, parked trap, parked branch, live branch.
    always_comb begin
        w_sel_pc = '0;
        if (w_trap_acc) begin
            w_sel_pc = bus.trap_pc_i;
        end else if (w_hold && r_pend_trap) begin
            w_sel_pc = r_pend_pc;
        end else if (w_hold) begin
            w_sel_pc = r_pend_pc;
        end else if (w_branch_acc) begin
            w_sel_pc = bus.branch_pc_i;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_BOOT: begin
                // Leaving when the counter shows 1 gives exactly BOOT_WAIT
                // stalled cycles.
                if (r_boot_cnt <= c_BOOT_ONE) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if ((w_trap_acc || w_branch_acc) && w_stall) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (!w_stall) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Gating on rst makes the outputs collapse to their
    // reset values the instant reset asserts, whatever the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl   = `CTRL_STATE_Stalled;
        w_pc_new = '0;
        w_flush  = 1'b0;
        if (rst && !w_in_boot) begin
            w_flush = w_trap_acc | w_branch_acc;
            if (w_sel_valid) begin
                w_pc_new = {w_sel_pc[63:2], 2'b00};
            end
            if (w_stall) begin
                w_ctrl = `CTRL_STATE_Stalled;
            end else if (w_sel_valid) begin
                w_ctrl = `CTRL_STATE_Branch;
            end else begin
                w_ctrl = `CTRL_STATE_Default;
            end
        end
    end

    assign bus.ctrl_signal_o      = w_ctrl;
    assign bus.pc_new_o           = w_pc_new;
    assign bus.flush_o            = w_flush;
    assign bus.redirect_pending_o = w_hold;
    assign bus.stall_timeout_o    = r_timeout;

    // Watchdog counts stalled cycles outside boot and saturates.
    always_comb begin
        w_wd_nxt = '0;
        if (!w_in_boot && (w_ctrl == `CTRL_STATE_Stalled)) begin
            w_wd_nxt = (r_wd_cnt < c_TIMEOUT) ? (r_wd_cnt + 16'd1) : r_wd_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Boot counter, parked redirect, watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_boot_cnt  <= c_BOOT_INIT;
            r_pend_trap <= 1'b0;
            r_pend_pc   <= '0;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_in_boot && (r_boot_cnt != '0)) begin
                r_boot_cnt <= r_boot_cnt - c_BOOT_ONE;
            end

            if (w_stall) begin
                // A trap always replaces whatever is parked; a branch can
                // only be accepted here when nothing is parked.
                if (w_trap_acc) begin
                    r_pend_trap <= 1'b1;
                    r_pend_pc   <= bus.trap_pc_i;
                end else if (w_branch_acc) begin
                    r_pend_trap <= 1'b0;
                    r_pend_pc   <= bus.branch_pc_i;
                end
            end else if (w_hold) begin
                r_pend_trap <= 1'b0;
                r_pend_pc   <= '0;
            end

            r_wd_cnt  <= w_wd_nxt;
            r_timeout <= r_timeout | (w_wd_nxt == c_TIMEOUT);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl_scheduler.sv
// ============================================================================
// Module      : tb_pc_ctrl_scheduler
// Description : Self-checking bench for pc_ctrl_scheduler. Directed steps
//               followed by random traffic, all compared against a
//               behavioural model of boot hold, redirect parking and the
//               stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl_scheduler;

    localparam int BOOT_WAIT     = 2;
    localparam int STALL_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_ctrl_scheduler_if bus_if ();

    pc_ctrl_scheduler #(
        .BOOT_WAIT    (BOOT_WAIT),
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "init";

    // Behavioural model state
    int          m_boot_left;
    bit          m_pending;
    logic [63:0] m_pend_pc;
    int          m_wd;
    bit          m_timeout;

    // Last observed outputs
    logic [1:0]  o_ctrl;
    logic [63:0] o_pc;
    logic        o_flush, o_pend, o_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot_left = BOOT_WAIT;
        m_pending   = 1'b0;
        m_pend_pc   = '0;
        m_wd        = 0;
        m_timeout   = 1'b0;
    endtask

    task automatic drive(input logic tv, input logic [63:0] tpc, input logic bv,
                         input logic [63:0] bpc, input logic ic, input logic hz, input logic dc);
        bus_if.trap_valid_i   = tv;
        bus_if.trap_pc_i      = tpc;
        bus_if.branch_valid_i = bv;
        bus_if.branch_pc_i    = bpc;
        bus_if.icache_stall_i = ic;
        bus_if.hazard_stall_i = hz;
        bus_if.dcache_stall_i = dc;
    endtask

    task automatic sample();
        o_ctrl  = bus_if.ctrl_signal_o;
        o_pc    = bus_if.pc_new_o;
        o_flush = bus_if.flush_o;
        o_pend  = bus_if.redirect_pending_o;
        o_to    = bus_if.stall_timeout_o;
    endtask

    // One clock cycle: drive on the falling edge, check mid-cycle against
    // the model, then advance the model across the rising edge.
    task automatic step(input logic tv, input logic [63:0] tpc, input logic bv,
                        input logic [63:0] bpc, input logic ic, input logic hz, input logic dc);
        bit          boot, stall, have;
        logic [63:0] tgt;
        logic [1:0]  e_ctrl;
        logic [63:0] e_pc;
        bit          e_flush;
        @(negedge clk);
        drive(tv, tpc, bv, bpc, ic, hz, dc);
        #1;
        boot  = (m_boot_left > 0);
        stall = ic | hz | dc;
        have  = 1'b0;
        tgt   = '0;
        if (!boot) begin
            if (tv) begin
                have = 1'b1; tgt = tpc;
            end else if (m_pending) begin
                have = 1'b1; tgt = m_pend_pc;
            end else if (bv) begin
                have = 1'b1; tgt = bpc;
            end
        end
        e_flush = !boot && (tv || (bv && !m_pending));
        e_ctrl  = (boot || stall) ? `CTRL_STATE_Stalled :
                  (have ? `CTRL_STATE_Branch : `CTRL_STATE_Default);
        e_pc    = have ? (tgt & ~64'h3) : 64'h0;
        sample();
        chk("ctrl",    64'(o_ctrl),  64'(e_ctrl));
        chk("pc_new",  o_pc,         e_pc);
        chk("flush",   64'(o_flush), 64'(e_flush));
        chk("pending", 64'(o_pend),  64'(m_pending));
        chk("timeout", 64'(o_to),    64'(m_timeout));
        @(posedge clk);
        if (boot) begin
            m_boot_left--;
            m_wd = 0;
        end else begin
            if (stall) begin
                if (m_wd < STALL_TIMEOUT) m_wd++;
                if (m_wd == STALL_TIMEOUT) m_timeout = 1'b1;
                if (tv) begin
                    m_pending = 1'b1; m_pend_pc = tpc;
                end else if (bv && !m_pending) begin
                    m_pending = 1'b1; m_pend_pc = bpc;
                end
            end else begin
                m_wd      = 0;
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        sample();
        chk({tag, "_ctrl"},    64'(o_ctrl),  64'(`CTRL_STATE_Stalled));
        chk({tag, "_pc"},      o_pc,         64'h0);
        chk({tag, "_flush"},   64'(o_flush), 64'h0);
        chk({tag, "_pending"}, 64'(o_pend),  64'h0);
        chk({tag, "_timeout"}, 64'(o_to),    64'h0);
    endtask

    initial begin
        drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        model_reset();

        // Reset state
        phase = "reset";
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_reset();

        // 1: boot hold then Default
        phase = "boot";
        idle(); chk("boot0", 64'(o_ctrl), 64'(`CTRL_STATE_Stalled));
        idle(); chk("boot1", 64'(o_ctrl), 64'(`CTRL_STATE_Stalled));
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("run_ctrl", 64'(o_ctrl), 64'(`CTRL_STATE_Default));
            chk("run_flush", 64'(o_flush), 64'h0);
        end

        // 2: zero-latency branch
        phase = "branch";
        step(1'b0, 64'h0, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
        chk("br_ctrl", 64'(o_ctrl), 64'(`CTRL_STATE_Branch));
        chk("br_pc", o_pc, 64'h8000_0100);
        chk("br_flush", 64'(o_flush), 64'h1);
        idle(); chk("br_after", 64'(o_ctrl), 64'(`CTRL_STATE_Default));

        // 3: branch parked during icache stall
        phase = "park";
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 64'h8000_0200, 1'b1, 1'b0, 1'b0);
        chk("pk_flush", 64'(o_flush), 64'h1);
        chk("pk_ctrl", 64'(o_ctrl), 64'(`CTRL_STATE_Stalled));
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("pk_pend", 64'(o_pend), 64'h1);
        repeat (2) step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("pk_rel_ctrl", 64'(o_ctrl), 64'(`CTRL_STATE_Branch));
        chk("pk_rel_pc", o_pc, 64'h8000_0200);
        idle(); chk("pk_cleared", 64'(o_pend), 64'h0);

        // 4: branch dropped during hold, trap overwrites
        phase = "hold";
        step(1'b0, 64'h0, 1'b1, 64'h8000_0200, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 64'h8000_0300, 1'b1, 1'b0, 1'b0);
        chk("hd_drop_flush", 64'(o_flush), 64'h0);
        step(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("hd_trap_flush", 64'(o_flush), 64'h1);
        idle();
        chk("hd_rel_pc", o_pc, 64'h8000_0000);
        // trap in the release cycle wins over the parked branch
        step(1'b0, 64'h0, 1'b1, 64'h8000_0500, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h8000_0600, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("hd_rel_trap_pc", o_pc, 64'h8000_0600);
        idle(); chk("hd_rel_trap_pend", 64'(o_pend), 64'h0);

        // 5: priority and low-bit masking
        phase = "prio";
        step(1'b1, 64'h8000_0000, 1'b1, 64'h8000_0400, 1'b0, 1'b0, 1'b0);
        chk("pr_trap_pc", o_pc, 64'h8000_0000);
        step(1'b0, 64'h0, 1'b1, 64'h8000_0402, 1'b0, 1'b0, 1'b0);
        chk("pr_mask_pc", o_pc, 64'h8000_0400);

        // 6: watchdog
        phase = "watchdog";
        for (int i = 0; i < STALL_TIMEOUT; i++) begin
            step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
            chk("wd_not_yet", 64'(o_to), 64'h0);
        end
        idle(); chk("wd_set", 64'(o_to), 64'h1);
        idle(); chk("wd_sticky", 64'(o_to), 64'h1);

        // Async reset mid-hold
        phase = "async_rst";
        step(1'b0, 64'h0, 1'b1, 64'h8000_0700, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 64'h8000_0800, 1'b1, 64'h8000_0900, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        release_reset();
        repeat (3) idle();
        chk("arst_lost", 64'(o_pend), 64'h0);

        // Random traffic
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                rst = 1'b0;
                drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
                model_reset();
                release_reset();
            end
            step(($urandom_range(15) == 0),
                 {$urandom, $urandom},
                 ($urandom_range(4) == 0),
                 {$urandom, $urandom},
                 ($urandom_range(5) == 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
